// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit controllers:
// FSM state encoding plus default baud divider and payload width.
package uart_pkg;

  localparam int UART_CLK_DIV   = 868;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin plus a falling-edge
// detector on the synchronised line; everything resets to the idle level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx_i,
  output logic rx_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // prev_q holds last cycle's synchronised level so a start edge is a 1->0 step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= uart_rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receiver: mid-bit sampling FSM feeding a one-deep valid/ready
// holding register, with one-cycle framing-error and overrun pulses.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = UART_CLK_DIV,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ZERO  = '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 byte_done;
  logic                 rx_s;
  logic                 fall;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx_i (uart_rx),
    .rx_s_o    (rx_s),
    .fall_o    (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Each bit-period wait counts down to zero and then samples on the following edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!rx_s) begin
          cnt_d   = BIT_LOAD;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = BIT_LOAD;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (rx_s) begin
          byte_done = 1'b1;
          state_d   = IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        // Stay here while the line is held low so a break is not seen as a new start
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A consumer taking the old byte in the completion cycle frees the slot for the new one
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ovr_d   = 1'b0;
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = (state_q != IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
